// File: rtl/ysyx_23060184_issue_ctrl.sv
// Decode-stage issue controller: scoreboards pending GPR writes, caps in-flight
// instructions and serialises ecall/mret/CSR writes behind a pipeline drain.
module ysyx_23060184_issue_ctrl #(
   parameter int unsigned NREG         = 32,
   parameter int unsigned CNT_W        = 2,
   parameter int unsigned MAX_INFLIGHT = 3,
   parameter int unsigned IF_W         = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            Ivalid,
   input  logic            Eready,
   input  logic [4:0]      Rs1D,
   input  logic [4:0]      Rs2D,
   input  logic [4:0]      RdD,
   input  logic            UseRs1D,
   input  logic            UseRs2D,
   input  logic            RegWriteD,
   input  logic            SerialD,
   input  logic            Wvalid,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   output logic            Dvalid,
   output logic            Dready,
   output logic            Stall,
   output logic [IF_W-1:0] Inflight,
   output logic            Err
);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pend_q [NREG];
   logic [CNT_W-1:0] pend_d [NREG];
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic             err_q, err_d;

   logic raw, waw, full, ok, fire;
   logic wr_d_en, wr_w_en;
   logic under_if, under_pend;

   // No bypass: hazards look only at registered scoreboard state.
   always_comb begin
      raw  = (UseRs1D && (Rs1D != '0) && (pend_q[Rs1D] != '0)) ||
             (UseRs2D && (Rs2D != '0) && (pend_q[Rs2D] != '0));
      waw  = RegWriteD && (RdD != '0) && (pend_q[RdD] == '1);
      full = (inflight_q == IF_W'(MAX_INFLIGHT));
      ok   = (state_q == S_RUN) && !raw && !waw && !full &&
             (!SerialD || (inflight_q == '0));
      Dvalid  = !rst && Ivalid && ok;
      Dready  = !rst && Eready && ok;
      Stall   = !rst && Ivalid && !ok;
      fire    = Dvalid && Eready;
      wr_d_en = fire && RegWriteD;
      wr_w_en = Wvalid && RegWriteW;
   end

   always_comb begin
      pend_d     = pend_q;
      pend_d[0]  = '0;
      under_pend = 1'b0;
      for (int unsigned i = 1; i < NREG; i++) begin
         if (wr_d_en && (RdD == 5'(i)) && !(wr_w_en && (RdW == 5'(i)))) begin
            pend_d[i] = pend_q[i] + CNT_W'(1);
         end else if (wr_w_en && (RdW == 5'(i)) && !(wr_d_en && (RdD == 5'(i)))) begin
            if (pend_q[i] == '0) begin
               under_pend = 1'b1;
            end else begin
               pend_d[i] = pend_q[i] - CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      under_if   = Wvalid && (inflight_q == '0);
      if (fire && !Wvalid) begin
         inflight_d = inflight_q + IF_W'(1);
      end else if (!fire && Wvalid && (inflight_q != '0)) begin
         inflight_d = inflight_q - IF_W'(1);
      end
      err_d = err_q || under_if || under_pend;
   end

   // DRAIN waits for the pipe to empty before the serial op may issue;
   // HOLD blocks everything until that serial op itself retires.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (Ivalid && SerialD && (inflight_q != '0)) begin
               state_d = S_DRAIN;
            end else if (fire && SerialD) begin
               state_d = S_HOLD;
            end
         end
         S_DRAIN: begin
            if (inflight_q == '0) state_d = S_RUN;
         end
         S_HOLD: begin
            if (Wvalid && (inflight_q == IF_W'(1))) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_RUN;
         pend_q     <= '{default: '0};
         inflight_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         inflight_q <= inflight_d;
         err_q      <= err_d;
      end
   end

   assign Inflight = inflight_q;
   assign Err      = err_q;

endmodule

// File: tb/tb_ysyx_23060184_issue_ctrl.sv
// Bench for the issue controller: directed vector table, randomized traffic
// against an in-order queue model, and reset / saturation corner cases.
module tb_ysyx_23060184_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       Ivalid, Eready, UseRs1D, UseRs2D, RegWriteD, SerialD;
   logic       Wvalid, RegWriteW;
   logic [4:0] Rs1D, Rs2D, RdD, RdW;
   logic       Dvalid, Dready, Stall, Err;
   logic [1:0] Inflight;
   logic       d1_dvalid, d1_dready, d1_stall, d1_err;
   logic [1:0] d1_inflight;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_23060184_issue_ctrl #(.NREG(32), .CNT_W(2), .MAX_INFLIGHT(3), .IF_W(2)) u_dut (
      .clk(clk), .rst(rst), .Ivalid(Ivalid), .Eready(Eready),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RegWriteD(RegWriteD), .SerialD(SerialD), .Wvalid(Wvalid),
      .RegWriteW(RegWriteW), .RdW(RdW), .Dvalid(Dvalid), .Dready(Dready),
      .Stall(Stall), .Inflight(Inflight), .Err(Err)
   );

   // One-bit counters saturate after a single pending write, exposing waw alone.
   ysyx_23060184_issue_ctrl #(.NREG(32), .CNT_W(1), .MAX_INFLIGHT(3), .IF_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .Ivalid(Ivalid), .Eready(Eready),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .UseRs1D(UseRs1D), .UseRs2D(UseRs2D),
      .RegWriteD(RegWriteD), .SerialD(SerialD), .Wvalid(Wvalid),
      .RegWriteW(RegWriteW), .RdW(RdW), .Dvalid(d1_dvalid), .Dready(d1_dready),
      .Stall(d1_stall), .Inflight(d1_inflight), .Err(d1_err)
   );

   typedef struct {
      logic       iv, er, ser, u1, u2, rw, wv, rww;
      logic [4:0] rs1, rs2, rd, rdw;
      logic       dv, dr, st;
      logic [1:0] inf;
   } vec_t;

   typedef struct {
      logic [4:0] rd;
      logic       wr;
   } ent_t;

   vec_t tbl[$];
   ent_t q[$];

   function automatic vec_t v(int iv, int ser, int u1, int rs1, int u2, int rs2,
                              int rw, int rd, int wv, int rww, int rdw,
                              int dv, int dr, int st, int inf);
      vec_t r;
      r.iv = 1'(iv);  r.er = 1'b1; r.ser = 1'(ser);
      r.u1 = 1'(u1);  r.rs1 = 5'(rs1); r.u2 = 1'(u2); r.rs2 = 5'(rs2);
      r.rw = 1'(rw);  r.rd = 5'(rd);
      r.wv = 1'(wv);  r.rww = 1'(rww); r.rdw = 5'(rdw);
      r.dv = 1'(dv);  r.dr = 1'(dr);  r.st = 1'(st); r.inf = 2'(inf);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      Ivalid = 0; Eready = 1; UseRs1D = 0; UseRs2D = 0; RegWriteD = 0; SerialD = 0;
      Wvalid = 0; RegWriteW = 0; Rs1D = 0; Rs2D = 0; RdD = 0; RdW = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic apply_vec(input vec_t t);
      Ivalid = t.iv; Eready = t.er; SerialD = t.ser;
      UseRs1D = t.u1; Rs1D = t.rs1; UseRs2D = t.u2; Rs2D = t.rs2;
      RegWriteD = t.rw; RdD = t.rd; Wvalid = t.wv; RegWriteW = t.rww; RdW = t.rdw;
   endtask

   function automatic int cnt(int r);
      int c = 0;
      foreach (q[k]) if (q[k].wr && (q[k].rd == 5'(r))) c++;
      return c;
   endfunction

   initial begin
      logic wait_drain, serial_busy;
      logic raw, waw, ok, fire;
      vec_t row;

      // Columns: iv ser u1 rs1 u2 rs2 rw rd wv rww rdw | dv dr st inflight
      // no-bypass RAW on x5
      tbl.push_back(v(1,0, 0,0, 0,0, 1,5, 0,0,0,  1,1,0,0));
      tbl.push_back(v(1,0, 1,5, 0,0, 1,6, 0,0,0,  0,0,1,1));
      tbl.push_back(v(1,0, 1,5, 0,0, 1,6, 0,0,0,  0,0,1,1));
      tbl.push_back(v(1,0, 1,5, 0,0, 1,6, 1,1,5,  0,0,1,1));
      tbl.push_back(v(1,0, 1,5, 0,0, 1,6, 0,0,0,  1,1,0,0));
      // in-flight cap
      tbl.push_back(v(1,0, 0,0, 0,0, 1,8, 0,0,0,  1,1,0,1));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,9, 0,0,0,  1,1,0,2));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,10, 0,0,0, 0,0,1,3));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,10, 1,1,6, 0,0,1,3));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,10, 0,0,0, 1,1,0,2));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,8,  0,0,0,3));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,9,  0,1,0,2));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,10, 0,1,0,1));
      // x7 saturation, x0 never tracked
      tbl.push_back(v(1,0, 0,0, 0,0, 1,7, 0,0,0,  1,1,0,0));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,7, 0,0,0,  1,1,0,1));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,7, 0,0,0,  1,1,0,2));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,7, 0,0,0,  0,0,1,3));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,7,  0,0,0,3));
      tbl.push_back(v(1,0, 1,0, 0,0, 1,0, 0,0,0,  1,1,0,2));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,7,  0,0,0,3));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,7,  0,1,0,2));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,0,  0,1,0,1));
      // same-cycle inc/dec of x3
      tbl.push_back(v(1,0, 0,0, 0,0, 1,3, 0,0,0,  1,1,0,0));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,3, 1,1,3,  1,1,0,1));
      tbl.push_back(v(1,0, 0,0, 1,3, 0,0, 0,0,0,  0,0,1,1));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,3,  0,1,0,1));
      tbl.push_back(v(1,0, 0,0, 1,3, 0,0, 0,0,0,  1,1,0,0));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,0,0,  0,1,0,1));
      row = v(1,0, 0,0, 0,0, 0,0, 0,0,0,  1,0,0,0); row.er = 1'b0; tbl.push_back(row);
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 0,0,0,  0,1,0,0));
      // serial drain / hold, with Ivalid dropping mid-drain
      tbl.push_back(v(1,0, 0,0, 0,0, 1,1, 0,0,0,  1,1,0,0));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,2, 0,0,0,  1,1,0,1));
      tbl.push_back(v(1,1, 0,0, 0,0, 0,0, 0,0,0,  0,0,1,2));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,1,  0,0,0,2));
      tbl.push_back(v(1,1, 0,0, 0,0, 0,0, 1,1,2,  0,0,1,1));
      tbl.push_back(v(1,1, 0,0, 0,0, 0,0, 0,0,0,  0,0,1,0));
      tbl.push_back(v(1,1, 0,0, 0,0, 0,0, 0,0,0,  1,1,0,0));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,4, 0,0,0,  0,0,1,1));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,4, 1,0,0,  0,0,1,1));
      tbl.push_back(v(1,0, 0,0, 0,0, 1,4, 0,0,0,  1,1,0,0));
      tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1,1,4,  0,1,0,1));

      do_reset();
      #1;
      chk("reset inflight", 32'(Inflight), 0);
      chk("reset err", 32'(Err), 0);

      foreach (tbl[i]) begin
         @(negedge clk);
         apply_vec(tbl[i]);
         #1;
         chk($sformatf("row%0d dvalid", i), 32'(Dvalid), 32'(tbl[i].dv));
         chk($sformatf("row%0d dready", i), 32'(Dready), 32'(tbl[i].dr));
         chk($sformatf("row%0d stall", i), 32'(Stall), 32'(tbl[i].st));
         chk($sformatf("row%0d inflight", i), 32'(Inflight), 32'(tbl[i].inf));
         chk($sformatf("row%0d err", i), 32'(Err), 0);
      end

      // Randomized traffic: in-order queue of issued instructions is the model.
      do_reset();
      q.delete();
      wait_drain = 1'b0;
      serial_busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         Ivalid    = ($urandom_range(0, 3) != 0);
         Eready    = ($urandom_range(0, 3) != 0);
         Rs1D      = 5'($urandom_range(0, 7));
         Rs2D      = 5'($urandom_range(0, 7));
         RdD       = 5'($urandom_range(0, 7));
         UseRs1D   = 1'($urandom_range(0, 1));
         UseRs2D   = 1'($urandom_range(0, 1));
         RegWriteD = ($urandom_range(0, 3) != 0);
         SerialD   = ($urandom_range(0, 11) == 0);
         Wvalid    = (q.size() != 0) && ($urandom_range(0, 2) == 0);
         RegWriteW = Wvalid ? q[0].wr : 1'($urandom_range(0, 1));
         RdW       = Wvalid ? q[0].rd : 5'($urandom_range(0, 31));

         raw  = (UseRs1D && Rs1D != 0 && cnt(int'(Rs1D)) > 0) ||
                (UseRs2D && Rs2D != 0 && cnt(int'(Rs2D)) > 0);
         waw  = RegWriteD && RdD != 0 && cnt(int'(RdD)) >= 3;
         ok   = !wait_drain && !serial_busy && !raw && !waw && (q.size() < 3) &&
                (!SerialD || q.size() == 0);
         fire = Ivalid && Eready && ok;
         #1;
         chk("rnd dvalid", 32'(Dvalid), 32'(Ivalid && ok));
         chk("rnd dready", 32'(Dready), 32'(Eready && ok));
         chk("rnd stall", 32'(Stall), 32'(Ivalid && !ok));
         chk("rnd inflight", 32'(Inflight), 32'(q.size()));
         chk("rnd err", 32'(Err), 0);

         if (wait_drain) begin
            if (q.size() == 0) wait_drain = 1'b0;
         end else if (serial_busy) begin
            if (Wvalid && q.size() == 1) serial_busy = 1'b0;
         end else if (Ivalid && SerialD && q.size() != 0) begin
            wait_drain = 1'b1;
         end else if (fire && SerialD) begin
            serial_busy = 1'b1;
         end
         if (Wvalid) void'(q.pop_front());
         if (fire) q.push_back('{rd: RdD, wr: RegWriteD});
      end

      // Retire underflow, then async reset in the middle of a drain.
      do_reset();
      @(negedge clk);
      Wvalid = 1;
      #1 chk("underflow err before edge", 32'(Err), 0);
      @(negedge clk);
      Wvalid = 0;
      #1;
      chk("underflow err sticky", 32'(Err), 1);
      chk("underflow inflight", 32'(Inflight), 0);
      @(negedge clk);
      Ivalid = 1; RegWriteD = 1; RdD = 1;
      #1 chk("pre-drain issue", 32'(Dvalid), 1);
      @(negedge clk);
      RegWriteD = 0; SerialD = 1;
      #1 chk("serial stalls", 32'(Stall), 1);
      @(negedge clk);
      #1 chk("drain stall", 32'(Stall), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst inflight", 32'(Inflight), 0);
      chk("rst err", 32'(Err), 0);
      chk("rst dvalid", 32'(Dvalid), 0);
      chk("rst dready", 32'(Dready), 0);
      chk("rst stall", 32'(Stall), 0);
      @(negedge clk);
      rst = 1'b0;
      SerialD = 0; UseRs1D = 1; Rs1D = 1; RegWriteD = 1; RdD = 7;
      #1;
      chk("post-rst issue", 32'(Dvalid), 1);
      chk("post-rst inflight", 32'(Inflight), 0);
      chk("cnt1 first x7", 32'(d1_dvalid), 1);
      @(negedge clk);
      UseRs1D = 0;
      #1;
      chk("cnt2 second x7", 32'(Dvalid), 1);
      chk("cnt1 waw stall", 32'(d1_stall), 1);
      chk("cnt1 waw dvalid", 32'(d1_dvalid), 0);
      chk("cnt1 inflight", 32'(d1_inflight), 1);
      @(negedge clk);
      idle_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
